fifo_wptr_full: RTL

Write-side pointer and full-flag generator for the asynchronous FIFO, clocked entirely in the write domain. It keeps the binary write pointer and advances it on accepted pushes. It feeds the next pointer through the Binary2Gray converter and publishes the registered Gray write pointer to the read domain. It also synchronizes the read domain's Gray pointer and produces registered full, almost-full and fill-level outputs for the writer and the dual-port RAM.

---
 rtl/fifo_pkg.sv | 7 +
 rtl/Binary2Gray.sv | 9 +
 rtl/gray_to_binary.sv | 11 +
 rtl/fifo_wptr_full.sv | 65 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared asynchronous-FIFO widths and pointer type
package fifo_pkg;
    localparam int ADDR_BITS = 4;
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int PTR_W = ADDR_BITS + 1;
    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/Binary2Gray.sv
// Binary2Gray: combinational binary to reflected-Gray converter
module Binary2Gray #(
    parameter int NUM_BITS = 5
) (
    input  logic [NUM_BITS-1:0] bin_i,
    output logic [NUM_BITS-1:0] gray_o
);
    assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational reflected-Gray to binary converter
module gray_to_binary #(
    parameter int NUM_BITS = 5
) (
    input  logic [NUM_BITS-1:0] gray_i,
    output logic [NUM_BITS-1:0] bin_o
);
    for (genvar g = 0; g < NUM_BITS; g++) begin : g_bit
        assign bin_o[g] = ^gray_i[NUM_BITS-1:g];
    end
endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer, Gray publish, read-pointer sync and full/level flags
module fifo_wptr_full #(
    parameter int ADDR_BITS = fifo_pkg::ADDR_BITS,
    parameter int AF_MARGIN = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS:0]   rptr_gray_i,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] waddr_o,
    output logic [ADDR_BITS:0]   wptr_gray_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [ADDR_BITS:0]   level_o
);
    localparam int PTR_W = ADDR_BITS + 1;
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_BITS - 1);

    logic [PTR_W-1:0] wbin_q, wbin_d, wgray_q, wgray_d, level_q, level_d, rbin_sync;
    (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] rq1_q, rq2_q;
    logic full_q, full_d, af_q, af_d, push;

    assign push = wr_en_i & ~full_q;
    assign mem_we_o = push & ~rst_i;

    Binary2Gray #(.NUM_BITS(PTR_W)) u_b2g (.bin_i(wbin_d), .gray_o(wgray_d));
    gray_to_binary #(.NUM_BITS(PTR_W)) u_g2b (.gray_i(rq2_q), .bin_o(rbin_sync));

    // full when the write pointer is exactly one lap ahead: top two Gray bits inverted
    always_comb begin
        wbin_d = wbin_q + PTR_W'(push);
        level_d = wbin_d - rbin_sync;
        full_d = wgray_d == (rq2_q ^ FULL_MASK);
        af_d = level_d >= AF_THRESH;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbin_q <= '0;
            wgray_q <= '0;
            rq1_q <= '0;
            rq2_q <= '0;
            level_q <= '0;
            full_q <= 1'b0;
            af_q <= 1'b0;
        end else begin
            wbin_q <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q <= rptr_gray_i;
            rq2_q <= rq1_q;
            level_q <= level_d;
            full_q <= full_d;
            af_q <= af_d;
        end
    end

    assign waddr_o = wbin_q[ADDR_BITS-1:0];
    assign wptr_gray_o = wgray_q;
    assign full_o = full_q;
    assign almost_full_o = af_q;
    assign level_o = level_q;
endmodule
